// File: rtl/tile_mul_scheduler_if.sv
// Accelerator-side bus of the tile multiply scheduler: operand select, tile offsets,
// accumulator clear and the start/ready/done handshake with poly_mul_wrapper.
interface tile_mul_scheduler_if #(
   parameter int IW = 4
);
   logic [1:0]    a_sel_o;
   logic [1:0]    b_sel_o;
   logic [IW-1:0] a_off_o;
   logic [IW-1:0] b_off_o;
   logic          acc_rst_poly_mul_o;
   logic          acc_start_o;
   logic          acc_ready_i;
   logic          acc_poly_mul_done_i;

   modport master (
      output a_sel_o, b_sel_o, a_off_o, b_off_o, acc_rst_poly_mul_o, acc_start_o,
      input  acc_ready_i, acc_poly_mul_done_i
   );

   modport slave (
      input  a_sel_o, b_sel_o, a_off_o, b_off_o, acc_rst_poly_mul_o, acc_start_o,
      output acc_ready_i, acc_poly_mul_done_i
   );
endinterface

// File: rtl/tile_mul_scheduler.sv
// Walks the four ciphertext tensor products tile pair by tile pair through poly_mul_wrapper.
// Optional stall counter enabled by defining TILE_SCHED_STALL_CNT_EN.
module tile_mul_scheduler #(
   parameter int DEGREE_N = 16,
   parameter int TILE_N   = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start_i,
   input  logic                abort_i,
   output logic                ready_o,
   output logic                done_o,
   output logic [1:0]          prod_o,
   output logic                proto_err_o,
   output logic [15:0]         stall_cnt_o,
   tile_mul_scheduler_if.master acc
);
   localparam int IW = $clog2(DEGREE_N);
   localparam logic [IW-1:0] OFF_STEP = IW'(TILE_N);
   localparam logic [IW-1:0] OFF_LAST = IW'(DEGREE_N - TILE_N);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_ISSUE,
      S_WAIT_DONE,
      S_DONE
   } state_t;

   state_t        state, state_nxt;
   logic [1:0]    prod, prod_nxt;
   logic [1:0]    a_sel, a_sel_nxt;
   logic [1:0]    b_sel, b_sel_nxt;
   logic [IW-1:0] a_off, a_off_nxt;
   logic [IW-1:0] b_off, b_off_nxt;
   logic          proto_err, proto_err_nxt;
   logic          xfer;

   // Product order: c11*c01, c10*c01, c11*c00, c10*c00
   function automatic logic [1:0] a_of(input logic [1:0] p);
      return p[0] ? 2'd2 : 2'd3;
   endfunction

   function automatic logic [1:0] b_of(input logic [1:0] p);
      return p[1] ? 2'd0 : 2'd1;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         prod      <= '0;
         a_sel     <= '0;
         b_sel     <= '0;
         a_off     <= '0;
         b_off     <= '0;
         proto_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         prod      <= prod_nxt;
         a_sel     <= a_sel_nxt;
         b_sel     <= b_sel_nxt;
         a_off     <= a_off_nxt;
         b_off     <= b_off_nxt;
         proto_err <= proto_err_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      prod_nxt      = prod;
      a_sel_nxt     = a_sel;
      b_sel_nxt     = b_sel;
      a_off_nxt     = a_off;
      b_off_nxt     = b_off;
      proto_err_nxt = proto_err;
      xfer          = (state == S_ISSUE) && acc.acc_ready_i;

      unique case (state)
         S_IDLE: begin
            if (start_i) begin
               state_nxt     = S_CLEAR;
               prod_nxt      = 2'd0;
               a_sel_nxt     = a_of(2'd0);
               b_sel_nxt     = b_of(2'd0);
               a_off_nxt     = '0;
               b_off_nxt     = '0;
               proto_err_nxt = 1'b0;
            end
         end
         S_CLEAR: state_nxt = S_ISSUE;
         S_ISSUE: begin
            // A offset is the fast index; both wrap to 0 after the last pair
            if (xfer) begin
               a_off_nxt = a_off + OFF_STEP;
               if (a_off == OFF_LAST) begin
                  b_off_nxt = b_off + OFF_STEP;
                  if (b_off == OFF_LAST) state_nxt = S_WAIT_DONE;
               end
            end
         end
         S_WAIT_DONE: begin
            if (acc.acc_poly_mul_done_i) begin
               if (prod == 2'd3) begin
                  state_nxt = S_DONE;
               end else begin
                  state_nxt = S_CLEAR;
                  prod_nxt  = prod + 2'd1;
                  a_sel_nxt = a_of(prod + 2'd1);
                  b_sel_nxt = b_of(prod + 2'd1);
               end
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase

      // A done outside WAIT_DONE is flagged but never consumed
      if (acc.acc_poly_mul_done_i && (state != S_WAIT_DONE)) proto_err_nxt = 1'b1;

      if (abort_i && (state != S_IDLE)) begin
         state_nxt = S_IDLE;
         prod_nxt  = 2'd0;
         a_sel_nxt = 2'd0;
         b_sel_nxt = 2'd0;
         a_off_nxt = '0;
         b_off_nxt = '0;
      end
   end

   assign ready_o                = (state == S_IDLE);
   assign done_o                 = (state == S_DONE);
   assign prod_o                 = prod;
   assign proto_err_o            = proto_err;
   assign acc.acc_start_o        = (state == S_ISSUE);
   assign acc.acc_rst_poly_mul_o = (state == S_CLEAR);
   assign acc.a_sel_o            = a_sel;
   assign acc.b_sel_o            = b_sel;
   assign acc.a_off_o            = a_off;
   assign acc.b_off_o            = b_off;

`ifdef TILE_SCHED_STALL_CNT_EN
   logic [15:0] stall_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if ((state == S_IDLE) && start_i) begin
         stall_cnt <= '0;
      end else if ((state == S_ISSUE) && !acc.acc_ready_i && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end

   assign stall_cnt_o = stall_cnt;
`else
   assign stall_cnt_o = '0;
`endif

endmodule

// File: doc/tile_mul_scheduler.md
# tile_mul_scheduler

Sequences the four ciphertext tensor products (c11·c01, c10·c01, c11·c00, c10·c00) through the poly_mul_wrapper accelerator, one TILE_N×TILE_N tile pair at a time. Sits between the top-level load/store control and the accelerator. It selects operand polynomials and tile offsets, issues start/ready handshakes, pulses the per-product accumulator clear, and waits for product completion before advancing. Operand storage and the memory ports stay outside this block.

## Interface
- DEGREE_N, 16: polynomial degree (coefficients per polynomial); power of two.
- TILE_N, 4: coefficients per tile; power of two, TILE_N ≤ DEGREE_N.
- Derived: T = DEGREE_N/TILE_N tiles per polynomial; IW = $clog2(DEGREE_N).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- start_i  in  1  begin full 4-product sequence; sampled only in IDLE.
- abort_i  in  1  abandon sequence; highest priority after rst.
- ready_o  out  1  high in IDLE.
- done_o  out  1  one-cycle pulse when all four products complete.
- prod_o  out  2  current product index 0..3.
- a_sel_o  out  2  operand A polynomial: 0=c00, 1=c01, 2=c10, 3=c11.
- b_sel_o  out  2  operand B polynomial, same encoding.
- a_off_o  out  IW  coefficient offset of A tile (multiple of TILE_N).
- b_off_o  out  IW  coefficient offset of B tile.
- acc_rst_poly_mul_o  out  1  active-high one-cycle clear of accelerator accumulators.
- acc_start_o  out  1  tile pair valid; accelerator presents its own ready.
- acc_ready_i  in  1  accelerator accepts tile pair this cycle.
- acc_poly_mul_done_i  in  1  accelerator finished current product.
- proto_err_o  out  1  sticky: poly_mul_done seen outside WAIT_DONE.
- stall_cnt_o  out  16  stall cycle count (see Configuration).

## Operation
- States: IDLE, CLEAR, ISSUE, WAIT_DONE, DONE.
- IDLE: ready_o=1. start_i → CLEAR, prod=0, a_off=b_off=0, proto_err cleared.
- CLEAR: acc_rst_poly_mul_o=1 for exactly one cycle → ISSUE.
- ISSUE: acc_start_o=1. Transfer happens when acc_start_o & acc_ready_i. On transfer, a_off steps by TILE_N. On wrap (DEGREE_N−TILE_N → 0), b_off steps by TILE_N. On transfer of pair (DEGREE_N−TILE_N, DEGREE_N−TILE_N), go to WAIT_DONE with offsets back at 0.
- WAIT_DONE: acc_start_o=0. On acc_poly_mul_done_i, go to CLEAR with prod+1 if prod<3, else go to DONE.
- DONE: done_o=1 for one cycle → IDLE.
- Operand map by prod: 0:(a=3,b=1), 1:(a=2,b=1), 2:(a=3,b=0), 3:(a=2,b=0).
- Offsets are IW-bit and wrap modulo DEGREE_N. T·T transfers per product; 4·T·T per sequence.
- start_i outside IDLE is ignored.
- acc_poly_mul_done_i in any state other than WAIT_DONE sets proto_err_o. It does not change state.
- abort_i in any non-IDLE state → IDLE next cycle. No done_o; acc_start_o drops the same edge; offsets and prod reset.

## Timing
- Reset values: state IDLE, ready_o=1, all other outputs 0, stall_cnt_o=0.
- start_i at edge k → CLEAR during cycle k+1 → acc_start_o first high in cycle k+2.
- a_sel_o, b_sel_o, a_off_o, b_off_o are registered. They hold stable while acc_start_o=1 and acc_ready_i=0.
- With acc_ready_i tied high, back-to-back transfers run one per cycle. Minimum cycles per product = 1 (CLEAR) + T·T + 1 (done, if it arrives the first WAIT_DONE cycle).
- Minimum start-to-done_o: 4·(T·T+2)+1 cycles.
- done seen in the same cycle as the final handshake is still in ISSUE. It sets proto_err_o and is not consumed.
- Async rst mid-sequence: all outputs return to reset values immediately.

## Configuration
- TILE_SCHED_STALL_CNT_EN defined: stall_cnt_o counts cycles with acc_start_o=1 & acc_ready_i=0. It saturates at 0xFFFF and clears on start_i in IDLE.
- Undefined: counter logic is omitted and stall_cnt_o is tied to 0. The port exists in both builds.

## Test plan
- DEGREE_N=8, TILE_N=4, ready tied 1, done returned 1 cycle after entering WAIT_DONE → 16 transfers with (a_off,b_off) = (0,0),(4,0),(0,4),(4,4) per product. Four acc_rst pulses. done_o at cycle 4·(4+2)+1=25 after start.
- Verify a_sel/b_sel sequence over the run: (3,1),(2,1),(3,0),(2,0).
- Hold acc_ready_i low 3 cycles on the second transfer → outputs stable across the stall. With macro defined, stall_cnt_o=3; without it, 0.
- Assert abort_i during product 2 ISSUE → IDLE next cycle, no done_o. A new start_i then begins again at prod 0, offsets 0.
- Pulse acc_poly_mul_done_i during ISSUE → proto_err_o=1, state unchanged, sequence still completes. The next start_i clears proto_err_o.
- Assert rst asynchronously mid-WAIT_DONE → outputs at reset values before the next clk edge. start_i during ISSUE is ignored.
